gps_rmc_parser: RTL and testbench

- Receives the GPS module's NMEA serial stream and decodes $GPRMC sentences into binary UTC time/date plus a lock flag.
- Sits directly upstream of the launcher stage and drives its GPS_locked / GPS_year / GPS_mouth / GPS_day / GPS_hour / GPS_minutes / GPS_second inputs.
- Contains its own 8N1 UART receiver and verifies the NMEA checksum.
- Updates outputs only on a fully validated sentence.

---
 rtl/gps_rmc_parser.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_gps_rmc_parser.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/gps_rmc_parser.sv
// NMEA $GPRMC decoder: 8N1 UART receiver, sentence parser with checksum check,
// binary UTC time/date outputs and a lock flag that expires after a silent period.
module gps_rmc_parser #(
    parameter int unsigned BAUD_DIV    = 1042,
    parameter int unsigned MAX_LEN     = 82,
    parameter int unsigned TIMEOUT_CYC = 30000000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        GPS_RX,
    output logic        GPS_locked,
    output logic [15:0] GPS_year,
    output logic [7:0]  GPS_mouth,
    output logic [7:0]  GPS_day,
    output logic [7:0]  GPS_hour,
    output logic [7:0]  GPS_minutes,
    output logic [7:0]  GPS_second,
    output logic        GPS_valid,
    output logic        FRAME_ERR,
    output logic        CKSUM_ERR
);

    localparam int unsigned BW = $clog2(BAUD_DIV + 1);
    localparam int unsigned CW = $clog2(MAX_LEN + 2);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [BW-1:0] HALF_LAST = BW'(BAUD_DIV / 2 - 1);
    localparam logic [BW-1:0] FULL_LAST = BW'(BAUD_DIV - 1);
    localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT_CYC);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] LEN_MAX   = CW'(MAX_LEN);

    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_STAR   = 8'h2A;
    localparam logic [7:0] CH_COMMA  = 8'h2C;
    localparam logic [7:0] CH_A      = 8'h41;

    // ---------------- UART receiver ----------------
    typedef enum logic [2:0] {U_IDLE, U_START, U_DATA, U_STOP, U_WAIT} uart_state_t;

    uart_state_t   u_state, u_next;
    logic          rx_meta, rx_sync;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg, rx_byte;
    logic          byte_valid;
    logic          tick_c;

    always_comb begin
        u_next = u_state;
        tick_c = (baud_cnt == ((u_state == U_START) ? HALF_LAST : FULL_LAST));
        case (u_state)
            U_IDLE:  if (!rx_sync) u_next = U_START;
            U_START: if (tick_c) u_next = rx_sync ? U_IDLE : U_DATA;
            U_DATA:  if (tick_c && bit_idx == 3'd7) u_next = U_STOP;
            U_STOP:  if (tick_c) u_next = rx_sync ? U_IDLE : U_WAIT;
            U_WAIT:  if (rx_sync) u_next = U_IDLE;
            default: u_next = U_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            u_state    <= U_IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            FRAME_ERR  <= 1'b0;
        end else begin
            rx_meta  <= GPS_RX;
            rx_sync  <= rx_meta;
            u_state  <= u_next;
            baud_cnt <= (u_state == U_IDLE || u_state == U_WAIT || tick_c) ? '0 : baud_cnt + BW'(1);
            if (u_state == U_START) begin
                bit_idx <= '0;
            end else if (u_state == U_DATA && tick_c) begin
                shreg   <= {rx_sync, shreg[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
            byte_valid <= (u_state == U_STOP) && tick_c && rx_sync;
            FRAME_ERR  <= (u_state == U_STOP) && tick_c && !rx_sync;
            if (u_state == U_STOP && tick_c && rx_sync) rx_byte <= shreg;
        end
    end

    // ---------------- sentence parser ----------------
    typedef enum logic [2:0] {P_IDLE, P_HDR, P_FIELD, P_CK_HI, P_CK_LO, P_COMMIT} parse_state_t;

    parse_state_t  p_state, p_next;
    logic [7:0]    xor_acc, status;
    logic [CW-1:0] char_cnt;
    logic [2:0]    hdr_idx, pos;
    logic [3:0]    field_idx, tens, ck_hi;
    logic [7:0]    sh_hour, sh_min, sh_sec, sh_day, sh_mon, sh_yy;
    logic [TW-1:0] tmo_cnt;

    logic          restart_c, acc_c, next_field_c, capture_c, status_c, ck_hi_c;
    logic          commit_c, cksum_bad_c;
    logic          is_digit_c, hex_ok_c, capt_field_c, end_ok_c, range_ok_c, too_long_c;
    logic [3:0]    hex_val_c;
    logic [7:0]    hdr_char_c, pair_val_c;
    logic [CW-1:0] cnt_inc_c;

    always_comb begin
        is_digit_c   = (rx_byte >= 8'h30) && (rx_byte <= 8'h39);
        hex_ok_c     = is_digit_c || ((rx_byte >= 8'h41) && (rx_byte <= 8'h46));
        hex_val_c    = is_digit_c ? rx_byte[3:0] : rx_byte[3:0] + 4'd9;
        capt_field_c = (field_idx == 4'd1 || field_idx == 4'd9) && (pos < 3'd6);
        end_ok_c     = (field_idx > 4'd9) || (field_idx == 4'd9 && pos >= 3'd6);
        range_ok_c   = (sh_hour <= 8'd23) && (sh_min <= 8'd59) && (sh_sec <= 8'd60) &&
                       (sh_mon != 8'd0) && (sh_mon <= 8'd12) &&
                       (sh_day != 8'd0) && (sh_day <= 8'd31);
        cnt_inc_c    = char_cnt + CW'(1);
        too_long_c   = cnt_inc_c > LEN_MAX;
        pair_val_c   = 8'(tens) * 8'd10 + 8'(rx_byte[3:0]);
        case (hdr_idx)
            3'd0:    hdr_char_c = 8'h47;
            3'd1:    hdr_char_c = 8'h50;
            3'd2:    hdr_char_c = 8'h52;
            3'd3:    hdr_char_c = 8'h4D;
            3'd4:    hdr_char_c = 8'h43;
            default: hdr_char_c = CH_COMMA;
        endcase
    end

    // Next state plus one-cycle strobes steering the datapath below.
    always_comb begin
        p_next       = p_state;
        restart_c    = 1'b0;
        acc_c        = 1'b0;
        next_field_c = 1'b0;
        capture_c    = 1'b0;
        status_c     = 1'b0;
        ck_hi_c      = 1'b0;
        commit_c     = 1'b0;
        cksum_bad_c  = 1'b0;
        if (FRAME_ERR || p_state == P_COMMIT) begin
            p_next = P_IDLE;
        end else if (byte_valid) begin
            if (rx_byte == CH_DOLLAR) begin
                p_next    = P_HDR;
                restart_c = 1'b1;
            end else if (p_state != P_IDLE && too_long_c) begin
                p_next = P_IDLE;
            end else begin
                case (p_state)
                    P_HDR: begin
                        if (rx_byte != hdr_char_c) begin
                            p_next = P_IDLE;
                        end else begin
                            acc_c = 1'b1;
                            if (hdr_idx == 3'd5) p_next = P_FIELD;
                        end
                    end
                    P_FIELD: begin
                        if (rx_byte == CH_STAR) begin
                            p_next = (end_ok_c && range_ok_c) ? P_CK_HI : P_IDLE;
                        end else if (rx_byte == CH_COMMA) begin
                            if (capt_field_c) begin
                                p_next = P_IDLE;
                            end else begin
                                acc_c        = 1'b1;
                                next_field_c = 1'b1;
                            end
                        end else if (capt_field_c && !is_digit_c) begin
                            p_next = P_IDLE;
                        end else begin
                            acc_c     = 1'b1;
                            capture_c = capt_field_c;
                            status_c  = (field_idx == 4'd2) && (pos == 3'd0);
                        end
                    end
                    P_CK_HI: begin
                        if (hex_ok_c) begin
                            ck_hi_c = 1'b1;
                            p_next  = P_CK_LO;
                        end else begin
                            p_next = P_IDLE;
                        end
                    end
                    P_CK_LO: begin
                        if (hex_ok_c && {ck_hi, hex_val_c} == xor_acc) begin
                            commit_c = 1'b1;
                            p_next   = P_COMMIT;
                        end else begin
                            cksum_bad_c = hex_ok_c;
                            p_next      = P_IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            p_state   <= P_IDLE;
            xor_acc   <= '0;
            char_cnt  <= '0;
            hdr_idx   <= '0;
            field_idx <= '0;
            pos       <= '0;
            tens      <= '0;
            status    <= '0;
            ck_hi     <= '0;
            sh_hour   <= '0;
            sh_min    <= '0;
            sh_sec    <= '0;
            sh_day    <= '0;
            sh_mon    <= '0;
            sh_yy     <= '0;
        end else begin
            p_state <= p_next;
            if (restart_c) begin
                xor_acc   <= '0;
                char_cnt  <= CW'(1);
                hdr_idx   <= '0;
                field_idx <= '0;
                pos       <= '0;
                status    <= '0;
            end else begin
                if (byte_valid && p_state != P_IDLE) char_cnt <= cnt_inc_c;
                if (acc_c) xor_acc <= xor_acc ^ rx_byte;
                if (acc_c && p_state == P_HDR) begin
                    hdr_idx <= hdr_idx + 3'd1;
                    if (hdr_idx == 3'd5) begin
                        field_idx <= 4'd1;
                        pos       <= '0;
                    end
                end
                if (next_field_c) begin
                    if (field_idx != 4'hF) field_idx <= field_idx + 4'd1;
                    pos <= '0;
                end else if (acc_c && p_state == P_FIELD && pos != 3'd7) begin
                    pos <= pos + 3'd1;
                end
                // Even positions hold the tens digit; odd positions complete the pair.
                if (capture_c) begin
                    if (!pos[0]) begin
                        tens <= rx_byte[3:0];
                    end else if (field_idx == 4'd1) begin
                        case (pos[2:1])
                            2'd0:    sh_hour <= pair_val_c;
                            2'd1:    sh_min  <= pair_val_c;
                            default: sh_sec  <= pair_val_c;
                        endcase
                    end else begin
                        case (pos[2:1])
                            2'd0:    sh_day <= pair_val_c;
                            2'd1:    sh_mon <= pair_val_c;
                            default: sh_yy  <= pair_val_c;
                        endcase
                    end
                end
                if (status_c) status <= rx_byte;
                if (ck_hi_c) ck_hi <= hex_val_c;
            end
        end
    end

    // Output registers and lock timeout; commit wins over timeout expiry.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            GPS_locked  <= 1'b0;
            GPS_year    <= '0;
            GPS_mouth   <= '0;
            GPS_day     <= '0;
            GPS_hour    <= '0;
            GPS_minutes <= '0;
            GPS_second  <= '0;
            GPS_valid   <= 1'b0;
            CKSUM_ERR   <= 1'b0;
            tmo_cnt     <= '0;
        end else begin
            GPS_valid <= commit_c;
            CKSUM_ERR <= cksum_bad_c;
            if (commit_c) begin
                GPS_locked  <= (status == CH_A);
                GPS_year    <= 16'd2000 + 16'(sh_yy);
                GPS_mouth   <= sh_mon;
                GPS_day     <= sh_day;
                GPS_hour    <= sh_hour;
                GPS_minutes <= sh_min;
                GPS_second  <= sh_sec;
                tmo_cnt     <= '0;
            end else if (tmo_cnt != TMO_MAX) begin
                tmo_cnt <= tmo_cnt + TW'(1);
                if (tmo_cnt == TMO_LAST) GPS_locked <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gps_rmc_parser.sv
// Directed bench for gps_rmc_parser: serialises NMEA sentences onto GPS_RX and
// checks decoded fields, error pulses and lock timeout against hand-computed values.
module tb_gps_rmc_parser;

    localparam int unsigned BD = 8;
    localparam int unsigned ML = 82;
    localparam int unsigned TO = 10000;

    logic        CLK    = 1'b0;
    logic        RESET  = 1'b1;
    logic        GPS_RX = 1'b1;
    logic        GPS_locked, GPS_valid, FRAME_ERR, CKSUM_ERR;
    logic [15:0] GPS_year;
    logic [7:0]  GPS_mouth, GPS_day, GPS_hour, GPS_minutes, GPS_second;

    gps_rmc_parser #(.BAUD_DIV(BD), .MAX_LEN(ML), .TIMEOUT_CYC(TO)) dut (
        .CLK(CLK), .RESET(RESET), .GPS_RX(GPS_RX),
        .GPS_locked(GPS_locked), .GPS_year(GPS_year), .GPS_mouth(GPS_mouth),
        .GPS_day(GPS_day), .GPS_hour(GPS_hour), .GPS_minutes(GPS_minutes),
        .GPS_second(GPS_second), .GPS_valid(GPS_valid),
        .FRAME_ERR(FRAME_ERR), .CKSUM_ERR(CKSUM_ERR)
    );

    always #50 CLK = ~CLK;

    int     errors = 0;
    int     checks = 0;
    int     n_valid = 0, n_ck = 0, n_fe = 0;
    longint cyc = 0, valid_cyc = 0, fall_cyc = 0;
    logic   prev_locked = 1'b0;

    // Pulse counters and event timestamps, sampled on the falling edge.
    always @(negedge CLK) begin
        cyc <= cyc + 1;
        if (GPS_valid === 1'b1) begin
            n_valid   <= n_valid + 1;
            valid_cyc <= cyc;
        end
        if (CKSUM_ERR === 1'b1) n_ck <= n_ck + 1;
        if (FRAME_ERR === 1'b1) n_fe <= n_fe + 1;
        if (prev_locked === 1'b1 && GPS_locked === 1'b0) fall_cyc <= cyc;
        prev_locked <= GPS_locked;
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + 8'(n) : 8'h37 + 8'(n);
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        GPS_RX = 1'b0;
        repeat (BD) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            GPS_RX = b[i];
            repeat (BD) @(negedge CLK);
        end
        GPS_RX = !bad_stop;
        repeat (BD) @(negedge CLK);
        if (bad_stop) begin
            GPS_RX = 1'b1;
            repeat (2 * BD) @(negedge CLK);
        end
    endtask

    task automatic send_raw(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b0);
    endtask

    // Sends '$' body '*' checksum CR LF; fe_idx selects a body byte sent with a low stop bit.
    task automatic send_sentence(input string body, input bit bad_ck, input int fe_idx);
        logic [7:0] ck;
        ck = 8'h00;
        for (int i = 0; i < body.len(); i++) ck = ck ^ body[i];
        if (bad_ck) ck = ck ^ 8'h01;
        send_byte(8'h24, 1'b0);
        for (int i = 0; i < body.len(); i++) send_byte(body[i], i == fe_idx);
        send_byte(8'h2A, 1'b0);
        send_byte(hexc(ck[7:4]), 1'b0);
        send_byte(hexc(ck[3:0]), 1'b0);
        send_byte(8'h0D, 1'b0);
        send_byte(8'h0A, 1'b0);
    endtask

    string  nominal;
    int     v0, c0, f0;
    longint t0;

    initial begin
        nominal = "GPRMC,123519.00,A,4807.038,N,01131.000,E,022.4,084.4,230324,003.1,W";

        RESET = 1'b1;
        repeat (3) @(negedge CLK);
        chk("rst_locked", GPS_locked, 0);
        chk("rst_year", GPS_year, 0);
        chk("rst_month", GPS_mouth, 0);
        chk("rst_day", GPS_day, 0);
        chk("rst_hour", GPS_hour, 0);
        chk("rst_minutes", GPS_minutes, 0);
        chk("rst_second", GPS_second, 0);
        chk("rst_valid", GPS_valid, 0);
        chk("rst_frame_err", FRAME_ERR, 0);
        chk("rst_cksum_err", CKSUM_ERR, 0);
        RESET = 1'b0;

        repeat (2000) @(negedge CLK);
        chk("idle_valid_pulses", n_valid, 0);
        chk("idle_cksum_pulses", n_ck, 0);
        chk("idle_frame_pulses", n_fe, 0);

        // Nominal sentence with status A.
        v0 = n_valid; c0 = n_ck;
        send_sentence(nominal, 1'b0, -1);
        chk("nom_valid_pulses", n_valid - v0, 1);
        chk("nom_cksum_pulses", n_ck - c0, 0);
        chk("nom_hour", GPS_hour, 12);
        chk("nom_minutes", GPS_minutes, 35);
        chk("nom_second", GPS_second, 19);
        chk("nom_day", GPS_day, 23);
        chk("nom_month", GPS_mouth, 3);
        chk("nom_year", GPS_year, 2024);
        chk("nom_locked", GPS_locked, 1);

        // Corrupted checksum: error pulse, outputs held.
        v0 = n_valid; c0 = n_ck;
        send_sentence(nominal, 1'b1, -1);
        chk("badck_cksum_pulses", n_ck - c0, 1);
        chk("badck_valid_pulses", n_valid - v0, 0);
        chk("badck_hour", GPS_hour, 12);
        chk("badck_second", GPS_second, 19);
        chk("badck_year", GPS_year, 2024);
        chk("badck_locked", GPS_locked, 1);

        // Status V still commits time/date but drops lock.
        v0 = n_valid;
        send_sentence("GPRMC,000001,V,,,,,,,010125,", 1'b0, -1);
        chk("v_valid_pulses", n_valid - v0, 1);
        chk("v_hour", GPS_hour, 0);
        chk("v_minutes", GPS_minutes, 0);
        chk("v_second", GPS_second, 1);
        chk("v_day", GPS_day, 1);
        chk("v_month", GPS_mouth, 1);
        chk("v_year", GPS_year, 2025);
        chk("v_locked", GPS_locked, 0);

        // Hour 24 is out of range: silent abort.
        v0 = n_valid; c0 = n_ck;
        send_sentence("GPRMC,240000,A,,,,,,,010125,", 1'b0, -1);
        chk("range_valid_pulses", n_valid - v0, 0);
        chk("range_cksum_pulses", n_ck - c0, 0);
        chk("range_hour_held", GPS_hour, 0);

        // Low stop bit mid-sentence: frame error, sentence never commits.
        v0 = n_valid; f0 = n_fe;
        send_sentence(nominal, 1'b0, 20);
        chk("fe_frame_pulses", n_fe - f0, 1);
        chk("fe_valid_pulses", n_valid - v0, 0);
        chk("fe_hour_held", GPS_hour, 0);

        // '$' after field 3 restarts; only the second sentence commits.
        v0 = n_valid;
        send_raw("$GPRMC,010203.00,A,4807.038,");
        send_sentence("GPRMC,235960,A,,,,,,,311299,", 1'b0, -1);
        chk("rs_valid_pulses", n_valid - v0, 1);
        chk("rs_hour", GPS_hour, 23);
        chk("rs_minutes", GPS_minutes, 59);
        chk("rs_second", GPS_second, 60);
        chk("rs_day", GPS_day, 31);
        chk("rs_month", GPS_mouth, 12);
        chk("rs_year", GPS_year, 2099);
        chk("rs_locked", GPS_locked, 1);

        // Silence until the lock expires.
        t0 = cyc;
        for (int i = 0; i < 2 * TO && fall_cyc <= t0; i++) @(negedge CLK);
        repeat (2) @(negedge CLK);
        chk("tmo_fell", (fall_cyc > t0) ? 1 : 0, 1);
        chk("tmo_delay", fall_cyc - valid_cyc, TO);
        chk("tmo_locked", GPS_locked, 0);
        chk("tmo_hour_held", GPS_hour, 23);
        chk("tmo_year_held", GPS_year, 2099);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
